tail_light_monitor: RTL
=======================

Name: tail_light_monitor

Overview:
- Passive checker/decoder on the 8-bit tail-light lamp bus Q.
- Left lamps are Q[7:4]; right lamps are Q[3:0].
- Samples Q every clock and classifies each side as off, on or sequencing.
- From the two side classes it recovers the 3-bit switch mode that produced the pattern, and flags illegal lamp transitions.
- Sits beside the lamp controller for on-chip self-check and for use as a bench scoreboard.

Parameters:
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  asynchronous, active-high reset
Q  input  8  lamp bus; [7:4] left, [3:0] right
MODE  output  3  decoded switch mode (0..6); holds the last valid value while VALID=0
VALID  output  1  MODE reflects a fully classified, consistent pattern
ERR  output  1  one-cycle pulse on an illegal transition or an inconsistent pattern
ERR_CNT  output  ERR_CNT_W  count of ERR cycles; saturates at all-ones

Behaviour:
- State:
  - PREV: 8-bit register holding the previous sample of Q.
  - Per-side class register, values PEND, OFF, ON, SEQ, BAD.
- Reset (async, immediate): PREV=0, both classes PEND, MODE=0, VALID=0, ERR=0, ERR_CNT=0.
- Each rising edge computes the next class per side from (p=PREV nibble, c=Q nibble, current class), then registers PREV<=Q, the classes, and all outputs.
  - Outputs therefore reflect the sample taken at that same edge, i.e. one-cycle latency.
- Legal sequence steps:
  - Left side: 0000->0001->0011->0111->1111.
  - Right side: 0000->1000->1100->1110->1111.
- Next-class rules, first match wins:
  - p=0000, c=0000 -> OFF.
  - p=1111, c=1111 -> ON.
  - (p,c) is a legal sequence step for that side -> SEQ.
  - p=1111, c=0000, class SEQ -> SEQ (wrap).
  - c=0000 -> PEND (mode-change clear).
  - p=0000, c=1111 -> PEND (entering ON).
  - Otherwise -> BAD (illegal step).
- Mode decode (left,right):
  - OFF,OFF=0
  - OFF,SEQ=1
  - SEQ,OFF=2
  - SEQ,SEQ=3 (modes 3 and 7 are indistinguishable; always report 3)
  - ON,ON=4
  - ON,SEQ=5
  - SEQ,ON=6
- Faults; ERR=1 for the cycle after any fault edge:
  - Either side BAD.
  - Combination OFF,ON or ON,OFF.
  - Phase fault: both sides SEQ and left nibble != bit-reverse(right nibble).
- VALID=1 when:
  - no side is PEND or BAD,
  - the combination is in the decode list, and
  - there is no phase fault.
  - MODE updates only when VALID=1.
- ERR_CNT increments by 1 on every edge that registers ERR=1, and holds at 2^ERR_CNT_W-1.
- BAD is not sticky: the next legal classification clears it.
- Q is a synchronous input from the controller, so no synchroniser is needed.

Test Plan:
1. Release RST with Q=0x00 held -> after the first edge MODE=0, VALID=1, ERR=0. Assert RST mid-run -> VALID, ERR and ERR_CNT are 0 immediately, before the next edge.
2. Q=0x00,0x08,0x0C,0x0E,0x0F,0x00,0x08 -> MODE=1, VALID=1 from the 0x08 sample onward, including across the 0x0F->0x00 wrap; ERR_CNT=0.
3. Q=0x00,0x18,0x3C,0x7E,0xFF,0x00,0x18 -> MODE=3, VALID=1 throughout after 0x18; no ERR.
4. Q=0x00,0xF8,0xFC -> VALID=0 on the 0xF8 sample (left PEND); MODE=5, VALID=1 on the 0xFC sample.
5. Q=0x08 then 0x04 -> ERR=1 for one cycle, VALID=0, ERR_CNT=1. Then 0x00,0x00 -> MODE=0, VALID=1, ERR=0.
6. Phase fault: Q=0x00,0x10,0x38 -> MODE=2 on the 0x10 sample; ERR=1 and VALID=0 on the 0x38 sample. Then force 300 illegal steps -> ERR_CNT saturates at 0xFF.

Source files
------------

// File: rtl/tail_light_monitor.sv
// Passive checker for the tail-light lamp bus: classifies each side, recovers
// the switch mode and flags illegal lamp transitions, with one-cycle latency.
module tail_light_monitor #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           Q,
  output logic [2:0]           MODE,
  output logic                 VALID,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam int unsigned NIB_W = 4;

  typedef enum logic [2:0] {
    CLS_PEND = 3'd0,
    CLS_OFF  = 3'd1,
    CLS_ON   = 3'd2,
    CLS_SEQ  = 3'd3,
    CLS_BAD  = 3'd4
  } cls_e;

  logic [7:0] prev_q;
  cls_e       l_cls, r_cls;
  cls_e       l_nxt, r_nxt;
  logic [2:0] mode_d;
  logic       valid_d;
  logic       err_d;

  // Left lamps fill from bit 0 upward, right lamps from bit 3 downward.
  function automatic logic legal_step(input logic left, input logic [NIB_W-1:0] p,
                                      input logic [NIB_W-1:0] c);
    logic ok;
    ok = 1'b0;
    if (left) begin
      if (p == 4'h0 || p == 4'h1 || p == 4'h3 || p == 4'h7)
        ok = (c == {p[2:0], 1'b1});
    end else begin
      if (p == 4'h0 || p == 4'h8 || p == 4'hC || p == 4'hE)
        ok = (c == {1'b1, p[3:1]});
    end
    return ok;
  endfunction

  function automatic cls_e next_class(input logic left, input logic [NIB_W-1:0] p,
                                      input logic [NIB_W-1:0] c, input cls_e cur);
    cls_e n;
    if (p == 4'h0 && c == 4'h0)                    n = CLS_OFF;
    else if (p == 4'hF && c == 4'hF)               n = CLS_ON;
    else if (legal_step(left, p, c))               n = CLS_SEQ;
    else if (p == 4'hF && c == 4'h0 && cur == CLS_SEQ) n = CLS_SEQ;
    else if (c == 4'h0)                            n = CLS_PEND;
    else if (p == 4'h0 && c == 4'hF)               n = CLS_PEND;
    else                                           n = CLS_BAD;
    return n;
  endfunction

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q  <= 8'h00;
      l_cls   <= CLS_PEND;
      r_cls   <= CLS_PEND;
      MODE    <= 3'd0;
      VALID   <= 1'b0;
      ERR     <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      prev_q <= Q;
      l_cls  <= l_nxt;
      r_cls  <= r_nxt;
      MODE   <= mode_d;
      VALID  <= valid_d;
      ERR    <= err_d;
      if (err_d && ERR_CNT != {ERR_CNT_W{1'b1}})
        ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
    end
  end

  // Next-state: per-side classification of the current sample
  always_comb begin
    l_nxt = next_class(1'b1, prev_q[7:4], Q[7:4], l_cls);
    r_nxt = next_class(1'b0, prev_q[3:0], Q[3:0], r_cls);
  end

  // Output decode from the freshly computed classes
  always_comb begin
    logic       combo_ok;
    logic       combo_fault;
    logic       phase_fault;
    logic [2:0] dec;
    combo_ok    = 1'b0;
    combo_fault = 1'b0;
    dec         = 3'd0;
    mode_d      = MODE;
    phase_fault = (l_nxt == CLS_SEQ) && (r_nxt == CLS_SEQ) &&
                  (Q[7:4] != {Q[0], Q[1], Q[2], Q[3]});
    case ({l_nxt, r_nxt})
      {CLS_OFF, CLS_OFF}: begin combo_ok = 1'b1; dec = 3'd0; end
      {CLS_OFF, CLS_SEQ}: begin combo_ok = 1'b1; dec = 3'd1; end
      {CLS_SEQ, CLS_OFF}: begin combo_ok = 1'b1; dec = 3'd2; end
      {CLS_SEQ, CLS_SEQ}: begin combo_ok = 1'b1; dec = 3'd3; end
      {CLS_ON,  CLS_ON }: begin combo_ok = 1'b1; dec = 3'd4; end
      {CLS_ON,  CLS_SEQ}: begin combo_ok = 1'b1; dec = 3'd5; end
      {CLS_SEQ, CLS_ON }: begin combo_ok = 1'b1; dec = 3'd6; end
      {CLS_OFF, CLS_ON }: combo_fault = 1'b1;
      {CLS_ON,  CLS_OFF}: combo_fault = 1'b1;
      default: ;
    endcase
    err_d   = (l_nxt == CLS_BAD) || (r_nxt == CLS_BAD) || combo_fault || phase_fault;
    valid_d = combo_ok && !phase_fault;
    if (valid_d)
      mode_d = dec;
  end

endmodule
